// File: rtl/mm_result_drain.sv
// mm_result_drain
// Receiving end of the matrix-multiply row-write port. Completed rows of C
// are captured into a BATCH_SIZE-row buffer and streamed out element by
// element, in row-major order, on a valid/ready stream toward the DMA.
// A row starts streaming as soon as it has been written, so draining
// overlaps filling. m_last marks the final element of a matrix and done
// pulses once that element has been accepted.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       arms the block for one matrix (honoured only when idle)
//   outputData  row of C, element k at [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   outputAddr  row index of outputData
//   outputWrEn  row write strobe
//   m_data      current stream element
//   m_valid     m_data valid
//   m_ready     downstream accepts
//   m_last      final element of row BATCH_SIZE-1
//   busy        block is not idle
//   done        one-cycle pulse after the last element transfers
//   overrun     sticky: a write hit a still-pending row or a bad address
module mm_result_drain #(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int OUTPUT_WIDTH        = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
    input  logic [LOG_BATCH_SIZE-1:0]               outputAddr,
    input  logic                                    outputWrEn,
    output logic [OUTPUT_WIDTH-1:0]                 m_data,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_last,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    overrun
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ROW = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW  = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL  = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);
    localparam logic [LOG_BATCH_SIZE:0]        ROW_COUNT = (LOG_BATCH_SIZE + 1)'(BATCH_SIZE);

    state_t                           state_r;
    state_t                           state_next_s;
    logic [OUTPUT_WIDTH-1:0]          buf_r [BATCH_SIZE][OUTPUT_FEATURES];
    logic [BATCH_SIZE-1:0]            row_valid_r;
    logic [BATCH_SIZE-1:0]            row_valid_next_s;
    logic [LOG_BATCH_SIZE-1:0]        rd_row_r;
    logic [LOG_BATCH_SIZE-1:0]        rd_row_next_s;
    logic [LOG_OUTPUT_FEATURES-1:0]   rd_col_r;
    logic [LOG_OUTPUT_FEATURES-1:0]   rd_col_next_s;
    logic                             overrun_r;
    logic                             overrun_next_s;
    logic [OUTPUT_WIDTH-1:0]          m_data_r;
    logic [OUTPUT_WIDTH-1:0]          m_data_next_s;
    logic                             m_valid_r;
    logic                             m_valid_next_s;
    logic                             m_last_r;
    logic                             m_last_next_s;
    logic                             busy_r;
    logic                             busy_next_s;
    logic                             done_r;
    logic                             done_next_s;
    logic                             xfer_s;
    logic                             last_col_s;
    logic                             last_row_s;
    logic                             addr_ok_s;
    logic                             wr_acc_s;
    logic                             wr_rej_s;

    // Handshake and write-qualification terms shared by the processes below.
    always_comb begin
        xfer_s     = (state_r == ST_STREAM) && m_ready;
        last_col_s = (rd_col_r == LAST_COL);
        last_row_s = (rd_row_r == LAST_ROW);
        addr_ok_s  = ({1'b0, outputAddr} < ROW_COUNT);
        // A row still marked valid has not fully drained yet, so a second
        // write to it would corrupt data in flight: drop it and flag it.
        if ((state_r != ST_IDLE) && outputWrEn) begin
            wr_acc_s = addr_ok_s && !row_valid_r[outputAddr];
            wr_rej_s = !(addr_ok_s && !row_valid_r[outputAddr]);
        end else begin
            wr_acc_s = 1'b0;
            wr_rej_s = 1'b0;
        end
    end

    // Next-state logic of the drain FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_WAIT_ROW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_ROW: begin
                if (row_valid_r[rd_row_r]) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_WAIT_ROW;
                end
            end
            ST_STREAM: begin
                if (xfer_s && last_col_s) begin
                    if (last_row_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_WAIT_ROW;
                    end
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the read pointers, row-valid flags and overrun flag.
    always_comb begin
        rd_row_next_s    = rd_row_r;
        rd_col_next_s    = rd_col_r;
        row_valid_next_s = row_valid_r;
        overrun_next_s   = overrun_r;
        if (state_r == ST_IDLE) begin
            if (start) begin
                rd_row_next_s    = {LOG_BATCH_SIZE{1'b0}};
                rd_col_next_s    = {LOG_OUTPUT_FEATURES{1'b0}};
                row_valid_next_s = {BATCH_SIZE{1'b0}};
                overrun_next_s   = 1'b0;
            end else begin
                overrun_next_s   = overrun_r;
            end
        end else begin
            // The accept/reject decision above used the pre-edge flags, so a
            // write racing the final transfer of its row is already rejected
            // and cannot collide with the clear below.
            if (wr_acc_s) begin
                row_valid_next_s[outputAddr] = 1'b1;
            end else if (wr_rej_s) begin
                overrun_next_s = 1'b1;
            end else begin
                overrun_next_s = overrun_r;
            end
            if (xfer_s) begin
                if (last_col_s) begin
                    rd_col_next_s              = {LOG_OUTPUT_FEATURES{1'b0}};
                    row_valid_next_s[rd_row_r] = 1'b0;
                    if (last_row_s) begin
                        rd_row_next_s = rd_row_r;
                    end else begin
                        rd_row_next_s = rd_row_r + {{(LOG_BATCH_SIZE-1){1'b0}}, 1'b1};
                    end
                end else begin
                    rd_col_next_s = rd_col_r + {{(LOG_OUTPUT_FEATURES-1){1'b0}}, 1'b1};
                end
            end else begin
                rd_col_next_s = rd_col_r;
            end
        end
    end

    // Output values for the next cycle; the buffer row being read is valid,
    // so no write can change it under the registered m_data.
    always_comb begin
        m_valid_next_s = (state_next_s == ST_STREAM);
        busy_next_s    = (state_next_s != ST_IDLE);
        done_next_s    = (state_next_s == ST_DONE);
        if (state_next_s == ST_STREAM) begin
            m_data_next_s = buf_r[rd_row_next_s][rd_col_next_s];
            m_last_next_s = (rd_row_next_s == LAST_ROW) && (rd_col_next_s == LAST_COL);
        end else begin
            m_data_next_s = m_data_r;
            m_last_next_s = 1'b0;
        end
    end

    // State, control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            row_valid_r <= {BATCH_SIZE{1'b0}};
            rd_row_r    <= {LOG_BATCH_SIZE{1'b0}};
            rd_col_r    <= {LOG_OUTPUT_FEATURES{1'b0}};
            overrun_r   <= 1'b0;
            m_data_r    <= {OUTPUT_WIDTH{1'b0}};
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            row_valid_r <= row_valid_next_s;
            rd_row_r    <= rd_row_next_s;
            rd_col_r    <= rd_col_next_s;
            overrun_r   <= overrun_next_s;
            m_data_r    <= m_data_next_s;
            m_valid_r   <= m_valid_next_s;
            m_last_r    <= m_last_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
        end
    end

    // Row buffer storage; contents are only meaningful while the row is valid.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int k = 0; k < OUTPUT_FEATURES; k++) begin
                buf_r[outputAddr][k] <= outputData[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            end
        end
    end

    assign m_data  = m_data_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_mm_result_drain.sv
// Self-checking bench for mm_result_drain: a short hand-derived vector table,
// directed sequences for the multi-cycle cases and randomized matrices,
// all checked against a transaction-level scoreboard of expected rows.
module tb_mm_result_drain;
    localparam int M = 8;
    localparam int O = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [O*W-1:0] outputData;
    logic [2:0]     outputAddr;
    logic           outputWrEn;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic           busy;
    logic           done;
    logic           overrun;

    always #5 clk = ~clk;

    mm_result_drain #(
        .BATCH_SIZE(M), .LOG_BATCH_SIZE(3), .OUTPUT_FEATURES(O),
        .LOG_OUTPUT_FEATURES(3), .OUTPUT_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .outputData(outputData),
        .outputAddr(outputAddr), .outputWrEn(outputWrEn), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
        .done(done), .overrun(overrun)
    );

    int n_vec = 0;
    int n_bad = 0;
    int pc    = 0;

    // Reference model: matrix phase (0 idle, 1 collecting/streaming, 2 done
    // cycle), elements transferred so far, rows held and their contents.
    int           phase = 0;
    int           n     = 0;
    bit           mvalid [M];
    logic [W-1:0] mdata  [M][O];
    bit           movr  = 1'b0;
    bit           hold_prev = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [O*W-1:0] mk_row(input int r, input logic [W-1:0] x);
        logic [O*W-1:0] v;
        for (int k = 0; k < O; k++) v[k*W +: W] = W'(r*16 + k) ^ x;
        return v;
    endfunction

    function automatic logic rdy_for(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return ((pc % 4) == 0) || ((pc % 4) == 3);
            default: return ($urandom_range(0, 9) < 7);
        endcase
    endfunction

    task automatic set_wr(input int r, input logic [W-1:0] x);
        outputWrEn = 1'b1;
        outputAddr = 3'(r);
        outputData = mk_row(r, x);
    endtask

    task automatic model_clear();
        for (int r = 0; r < M; r++) mvalid[r] = 1'b0;
        n    = 0;
        movr = 1'b0;
    endtask

    // One clock cycle: check what the DUT presents, advance the model across
    // the edge using the driven inputs, then check the post-edge flags.
    task automatic tick();
        logic         pv, pr, pl;
        logic [W-1:0] pd;
        bit           was_done;
        pv = m_valid; pr = m_ready; pl = m_last; pd = m_data;
        if (hold_prev) begin
            chk("hold_valid", 32'(pv), 32'd1);
            chk("hold_data", 32'(pd), 32'(hold_d));
            chk("hold_last", 32'(pl), 32'(hold_l));
        end
        if (phase == 1 && pv) begin
            chk("present_row_written", 32'(mvalid[n / O]), 32'd1);
            chk("stream_data", 32'(pd), 32'(mdata[n / O][n % O]));
            chk("stream_last", 32'(pl), 32'(n == M*O - 1));
        end else if (phase != 1) begin
            chk("valid_outside_stream", 32'(pv), 32'd0);
        end
        hold_prev = !rst && pv && !pr;
        hold_d = pd;
        hold_l = pl;
        if (rst) begin
            phase = 0;
            model_clear();
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                model_clear();
            end
        end else begin
            was_done = (phase == 2);
            if (outputWrEn) begin
                if (mvalid[outputAddr]) movr = 1'b1;
                else begin
                    mvalid[outputAddr] = 1'b1;
                    for (int k = 0; k < O; k++) mdata[outputAddr][k] = outputData[k*W +: W];
                end
            end
            if (phase == 1 && pv && pr) begin
                n++;
                if (n % O == 0) begin
                    mvalid[(n - 1) / O] = 1'b0;
                    if (n == M*O) phase = 2;
                end
            end
            if (was_done) phase = 0;
        end
        @(posedge clk);
        @(negedge clk);
        pc++;
        chk("done", 32'(done), 32'(phase == 2));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("overrun", 32'(overrun), 32'(movr));
        rst = 1'b0; start = 1'b0; outputWrEn = 1'b0;
    endtask

    task automatic drain(input int budget, input int mode, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            m_ready = rdy_for(mode);
            tick();
            cyc++;
        end
        chk("drain_reaches_done", 32'(done), 32'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
    endtask

    typedef struct {
        logic rst, start, wr; logic [2:0] addr; logic [W-1:0] x; logic rdy;
        logic e_valid; logic e_chkd; logic [W-1:0] e_data; logic e_busy, e_done, e_ovr;
    } vec_t;

    function automatic vec_t mkv(input logic r, s, w, input logic [2:0] a, input logic [W-1:0] x,
                                 input logic rd, ev, ecd, input logic [W-1:0] ed,
                                 input logic eb, edn, eo);
        vec_t v;
        v.rst = r; v.start = s; v.wr = w; v.addr = a; v.x = x; v.rdy = rd;
        v.e_valid = ev; v.e_chkd = ecd; v.e_data = ed; v.e_busy = eb; v.e_done = edn; v.e_ovr = eo;
        return v;
    endfunction

    vec_t tbl [13];
    int   cyc;
    int   cnt;
    int   ord [M];

    initial begin
        rst = 1'b1; start = 1'b0; outputWrEn = 1'b0; outputAddr = 3'd0;
        outputData = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_data", 32'(m_data), 32'd0);
        chk("reset_last", 32'(m_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // Cycle-by-cycle table: idle write, latency, busy start, overrun, reset.
        tbl[0]  = mkv(0,0,1,3'd0,16'h0000,1, 0,1,16'h0000, 0,0,0);
        tbl[1]  = mkv(0,1,0,3'd0,16'h0000,1, 0,0,16'h0000, 1,0,0);
        tbl[2]  = mkv(0,0,0,3'd0,16'h0000,1, 0,0,16'h0000, 1,0,0);
        tbl[3]  = mkv(0,0,1,3'd0,16'h1000,0, 0,0,16'h0000, 1,0,0);
        tbl[4]  = mkv(0,0,0,3'd0,16'h0000,0, 1,1,16'h1000, 1,0,0);
        tbl[5]  = mkv(0,1,0,3'd0,16'h0000,0, 1,1,16'h1000, 1,0,0);
        tbl[6]  = mkv(0,0,0,3'd0,16'h0000,1, 1,1,16'h1001, 1,0,0);
        tbl[7]  = mkv(0,1,0,3'd0,16'h0000,1, 1,1,16'h1002, 1,0,0);
        tbl[8]  = mkv(0,0,1,3'd0,16'hFFFF,1, 1,1,16'h1003, 1,0,1);
        tbl[9]  = mkv(0,0,1,3'd0,16'hFFFF,0, 1,1,16'h1003, 1,0,1);
        tbl[10] = mkv(0,0,0,3'd0,16'h0000,1, 1,1,16'h1004, 1,0,1);
        tbl[11] = mkv(1,0,1,3'd0,16'h0000,1, 0,1,16'h0000, 0,0,0);
        tbl[12] = mkv(0,0,1,3'd1,16'h0000,1, 0,1,16'h0000, 0,0,0);
        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; m_ready = tbl[i].rdy;
            outputWrEn = tbl[i].wr; outputAddr = tbl[i].addr;
            outputData = mk_row(int'(tbl[i].addr), tbl[i].x);
            tick();
            chk("tbl_valid", 32'(m_valid), 32'(tbl[i].e_valid));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("tbl_done", 32'(done), 32'(tbl[i].e_done));
            chk("tbl_overrun", 32'(overrun), 32'(tbl[i].e_ovr));
            if (tbl[i].e_chkd) chk("tbl_data", 32'(m_data), 32'(tbl[i].e_data));
        end

        // Basic: rows 0..7 on consecutive cycles, always ready.
        m_ready = 1'b1;
        do_start();
        cnt = 0;
        for (int r = 0; r < M; r++) begin set_wr(r, 16'h0000); tick(); cnt++; end
        drain(500, 0, cyc);
        chk("basic_start_to_done_cycles", 32'(cnt + cyc), 32'd73);
        chk("basic_transfers", 32'(n), 32'd64);
        chk("basic_overrun", 32'(overrun), 32'd0);
        tick();

        // Backpressure: m_ready 1,0,0,1 repeating.
        pc = 0;
        do_start();
        for (int r = 0; r < M; r++) begin m_ready = rdy_for(1); set_wr(r, 16'h0000); tick(); end
        drain(1000, 1, cyc);
        chk("bp_transfers", 32'(n), 32'd64);
        tick();

        // Out-of-order rows, one every 10 cycles.
        m_ready = 1'b1;
        do_start();
        for (int r = M - 1; r >= 1; r--) begin
            set_wr(r, 16'h0300);
            tick();
            repeat (9) tick();
        end
        set_wr(0, 16'h0300);
        tick();
        chk("ooo_valid_at_write_edge", 32'(m_valid), 32'd0);
        tick();
        chk("ooo_valid_after_next_edge", 32'(m_valid), 32'd1);
        drain(500, 0, cyc);
        chk("ooo_transfers", 32'(n), 32'd64);
        tick();

        // Overrun: row 2 twice under backpressure; first data must stream.
        do_start();
        m_ready = 1'b0;
        set_wr(2, 16'h0000); tick();
        set_wr(2, 16'hFFFF); tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        for (int r = 0; r < M; r++) begin
            if (r != 2) begin set_wr(r, 16'h0000); tick(); end
        end
        drain(500, 0, cyc);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        tick();
        do_start();
        chk("ovr_cleared_by_start", 32'(overrun), 32'd0);

        // Reset mid-stream after 20 transfers, then idle writes, then fresh matrix.
        rst = 1'b1; tick();
        do_start();
        for (int r = 0; r < M; r++) begin set_wr(r, 16'h0000); tick(); end
        set_wr(5, 16'h00F0); tick();
        cnt = 0;
        while (n < 20 && cnt < 200) begin tick(); cnt++; end
        chk("midrst_reached_20", 32'(n), 32'd20);
        rst = 1'b1; tick();
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        for (int r = 0; r < M; r++) begin set_wr(r, 16'hFFFF); tick(); end
        do_start();
        repeat (5) tick();
        chk("idle_writes_not_streamed", 32'(m_valid), 32'd0);
        for (int r = 0; r < M; r++) begin set_wr(r, 16'h0A00); tick(); end
        drain(500, 0, cyc);
        chk("midrst_fresh_transfers", 32'(n), 32'd64);
        tick();

        // Randomized matrices: shuffled rows, gaps, stray writes, busy starts.
        for (int mtx = 0; mtx < 6; mtx++) begin
            int i;
            for (int r = 0; r < M; r++) ord[r] = r;
            for (int r = M - 1; r > 0; r--) begin
                int j, t;
                j = int'($urandom_range(0, r));
                t = ord[r]; ord[r] = ord[j]; ord[j] = t;
            end
            do_start();
            i = 0; cyc = 0;
            while (phase != 0 && cyc < 3000) begin
                m_ready = rdy_for(2);
                if (i < M && $urandom_range(0, 2) == 0) begin
                    set_wr(ord[i], W'($urandom));
                    i++;
                end else if ($urandom_range(0, 15) == 0) begin
                    set_wr(int'($urandom_range(0, M - 1)), W'($urandom));
                end
                if ($urandom_range(0, 19) == 0) start = 1'b1;
                tick();
                cyc++;
            end
            chk("rand_matrix_completes", 32'(phase), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
